// File: rtl/vga_dac_out.sv
// vga_dac_out: registers RGB for the ADV7123, applies blanking, detects sync polarity and normalises syncs to active-low
module vga_dac_out #(
  parameter int BPP    = 8,
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11
) (
  input  logic           clk_vid,
  input  logic           reset,
  input  logic           ce_pix,
  input  logic [BPP-1:0] in_r,
  input  logic [BPP-1:0] in_g,
  input  logic [BPP-1:0] in_b,
  input  logic           in_hs,
  input  logic           in_vs,
  input  logic           in_de,
  input  logic           forced_blank,
  input  logic           csync_en,
  output logic [BPP-1:0] VGA_R,
  output logic [BPP-1:0] VGA_G,
  output logic [BPP-1:0] VGA_B,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_BLANK_N,
  output logic           VGA_SYNC_N,
  output logic           hs_pol,
  output logic           vs_pol
);
  logic [BPP-1:0] s1_r, s1_g, s1_b;
  logic s1_hs, s1_vs, s1_de, s1_fb, hs_prev, vs_prev;
  logic [HCNT_W-1:0] hi_cnt, lo_cnt, hi_len;
  logic [VCNT_W-1:0] vhi_cnt, vlo_cnt, vhi_len;
  logic hi_valid, vhi_valid, det_hs, det_vs;
  logic h_rise, h_fall, v_rise, v_fall, v_edge, blank;
  logic hs_pol_n, vs_pol_n, hs_act, vs_act;
  assign VGA_SYNC_N = 1'b0;
  always_comb begin
    h_rise   = s1_hs & ~hs_prev;
    h_fall   = ~s1_hs & hs_prev;
    v_rise   = s1_vs & ~vs_prev;
    v_fall   = ~s1_vs & vs_prev;
    v_edge   = s1_vs ^ vs_prev;
    blank    = ~s1_de | s1_fb;
    hs_pol_n = v_edge ? det_hs : hs_pol;
    vs_pol_n = v_edge ? det_vs : vs_pol;
    hs_act   = s1_hs ^ ~hs_pol_n;
    vs_act   = s1_vs ^ ~vs_pol_n;
  end
  // The low phase that just ended is compared as it is captured, so the first full line already decides det_hs.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      {s1_r, s1_g, s1_b} <= '0;
      {s1_hs, s1_vs, s1_de, s1_fb, hs_prev, vs_prev} <= '0;
      {hi_cnt, lo_cnt, hi_len} <= '0;
      {vhi_cnt, vlo_cnt, vhi_len} <= '0;
      {hi_valid, vhi_valid, det_hs, det_vs, hs_pol, vs_pol} <= '0;
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (ce_pix) begin
      s1_r    <= in_r;
      s1_g    <= in_g;
      s1_b    <= in_b;
      s1_hs   <= in_hs;
      s1_vs   <= in_vs;
      s1_de   <= in_de;
      s1_fb   <= forced_blank;
      hs_prev <= s1_hs;
      vs_prev <= s1_vs;
      hi_cnt  <= h_fall ? HCNT_W'(1) : (s1_hs && hi_cnt != '1) ? hi_cnt + 1'b1 : hi_cnt;
      lo_cnt  <= h_rise ? HCNT_W'(1) : (!s1_hs && lo_cnt != '1) ? lo_cnt + 1'b1 : lo_cnt;
      if (h_fall) begin
        hi_len   <= hi_cnt;
        hi_valid <= 1'b1;
      end
      if (h_rise && hi_valid && hi_len != lo_cnt)
        det_hs <= hi_len < lo_cnt;
      vhi_cnt <= v_fall ? VCNT_W'(1) : (h_rise && s1_vs && vhi_cnt != '1) ? vhi_cnt + 1'b1 : vhi_cnt;
      vlo_cnt <= v_rise ? VCNT_W'(1) : (h_rise && !s1_vs && vlo_cnt != '1) ? vlo_cnt + 1'b1 : vlo_cnt;
      if (v_fall) begin
        vhi_len   <= vhi_cnt;
        vhi_valid <= 1'b1;
      end
      if (v_rise && vhi_valid && vhi_len != vlo_cnt)
        det_vs <= vhi_len < vlo_cnt;
      hs_pol      <= hs_pol_n;
      vs_pol      <= vs_pol_n;
      VGA_R       <= blank ? '0 : s1_r;
      VGA_G       <= blank ? '0 : s1_g;
      VGA_B       <= blank ? '0 : s1_b;
      VGA_BLANK_N <= ~blank;
      VGA_HS      <= csync_en ? ~(hs_act ^ vs_act) : ~hs_act;
      VGA_VS      <= csync_en ? 1'b1 : ~vs_act;
    end
  end
endmodule

// File: doc/vga_dac_out.md
Name: vga_dac_out

Overview:
- Final video output stage between the core's video path and the ADV7123 VGA DAC pins on the Cyclone V SoC boards (DE10-Standard, DE1-SoC, SoCkit).
- Registers 8-bit RGB, applies blanking, and detects input HS/VS polarity.
- Normalizes sync to active-low VGA form, with optional composite sync on the HS pin.
- Fixed pipeline latency, so pixel and sync stay aligned.

Parameters:
- BPP, 8, colour bits per channel at the DAC.
- HCNT_W, 12, width of the HS phase-length counters (ce_pix units).
- VCNT_W, 11, width of the VS phase-length counters (line units).

Ports:
- clk_vid  in  1  video clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel enable; all pipeline and counter updates qualify on it
- in_r / in_g / in_b  in  BPP each  pixel colour
- in_hs / in_vs  in  1 each  raw syncs, arbitrary polarity
- in_de  in  1  data enable, active-high
- forced_blank  in  1  blank the video regardless of in_de
- csync_en  in  1  emit composite sync on VGA_HS
- VGA_R / VGA_G / VGA_B  out  BPP each  DAC colour
- VGA_HS / VGA_VS  out  1 each  active-low syncs
- VGA_BLANK_N  out  1  DAC blank, active-low
- VGA_SYNC_N  out  1  DAC sync-on-green; constant 0
- hs_pol / vs_pol  out  1 each  applied polarity; 1 = input is active-high

Behaviour:
Reset:
- Output values: RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, hs_pol=0, vs_pol=0.
- Clears all counters, valid flags and pipeline registers.
- Reset mid-frame takes effect on the next clk_vid edge, whatever ce_pix is doing.

Pipeline:
- S1 samples all inputs on ce_pix.
- S2 drives the outputs on ce_pix.
- Latency is exactly 2 ce_pix from input to pin. Outputs hold between enables.

Blanking:
- blank = ~S1.de | S1.forced_blank.
- When blank: VGA_BLANK_N=0 and RGB=0. Otherwise VGA_BLANK_N=1 and RGB = S1 colour.

HS polarity detection, on ce_pix, using S1.hs against previous S1.hs:
- hi_cnt/lo_cnt increment while S1.hs is 1/0 and saturate at 2^HCNT_W-1.
- Falling edge: hi_len <= hi_cnt; hi_cnt <= 1; hi_valid <= 1.
- Rising edge: lo_len <= lo_cnt; lo_cnt <= 1. If hi_valid, det_hs <= (hi_len < lo_len). Equal lengths keep det_hs unchanged.

VS polarity detection:
- Same scheme, but counters count lines: they increment on S1.hs rising edges, not on ce_pix.
- The VS rising/falling edge updates vlo_len/vhi_len and det_vs.
- Counters saturate at 2^VCNT_W-1.

Polarity apply:
- hs_pol <= det_hs and vs_pol <= det_vs only on a ce_pix where S1.vs differs from its previous value. This makes polarity switch at frame boundaries only, so there are no mid-line glitches.
- The apply cycle uses the new polarity for that same cycle's S2 sync.
- An S1.vs edge coinciding with a det update applies the previously committed det value.

Sync normalization:
- hs_act = S1.hs ^ ~hs_pol; vs_act = S1.vs ^ ~vs_pol.
- csync_en=0: VGA_HS <= ~hs_act, VGA_VS <= ~vs_act.
- csync_en=1: VGA_HS <= ~(hs_act ^ vs_act), VGA_VS <= 1.
- A csync_en change takes effect at the next ce_pix.

Other rules:
- ce_pix stuck low: all state frozen; outputs hold.
- Lengths of 1 are legal. Both sync inputs constant means no edges, so polarity never changes.

Test Plan:
- Reset: assert reset 3 clk mid-line with ce_pix=1 -> next cycle RGB=0, VGA_HS=1, VGA_VS=1, BLANK_N=0, hs_pol=vs_pol=0.
- Latency: ce_pix every 2 clk; feed de=1 with R=0x11,0x22,0x33 -> VGA_R shows 0x11 on the 2nd ce_pix after input, then 0x22, 0x33, with no skips; forced_blank=1 -> RGB=0, BLANK_N=0.
- 640x480 negative syncs (HS low 96 of 800, VS low 2 of 525) -> hs_pol=vs_pol=0 after the first frame boundary; VGA_HS low exactly 96 ce_pix per line; VGA_VS low 2 lines.
- Same timing with positive syncs after reset -> det_hs=1 after the 2nd HS rising edge; hs_pol/vs_pol become 1 only at a VS edge, never mid-line; pin pulse widths are unchanged from the negative case.
- csync_en=1, negative syncs -> VGA_VS=1 constant; VGA_HS pulses low for 96 ce_pix per line outside vsync, and is inverted (high 96, low 704) on the 2 vsync lines.
- Saturation: HS held high 5000 ce_pix then low 10 -> hi_len=4095, det_hs=0 (4095 > lo_len). Equal hi/lo lengths of 400 -> det_hs unchanged.
